// File: rtl/cpu_types_pkg.sv
// Shared CPU front-end types: fetch FSM states, the machine word and the PC step.
package cpu_types_pkg;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned PC_INC    = 4;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        FETCH,
        DROP,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode bundle: fetch drives the instruction slot, decode drives flow control.
interface fetch_unit_if
    import cpu_types_pkg::*;
(
    input logic CLK
);

    word_t ins;
    word_t npc;
    word_t redirectPC;
    logic  insValid;
    logic  stall;
    logic  redirect;
    logic  halt;
    logic  halted;

    modport fu (
        input  CLK, stall, redirect, redirectPC, halt,
        output ins, npc, insValid, halted
    );

    modport decode (
        input  CLK, ins, npc, insValid, halted,
        output stall, redirect, redirectPC, halt
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry (ins, npc) holding register with load/unload/flush; used by fetch_unit
// only when FETCH_SKID_EN is defined. Flush wins over load, load wins over unload.
module fetch_skid_buf #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic              unload,
    input  logic              flush,
    input  logic [WORD_W-1:0] d_ins,
    input  logic [WORD_W-1:0] d_npc,
    output logic              valid,
    output logic [WORD_W-1:0] q_ins,
    output logic [WORD_W-1:0] q_npc
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] ins_q, ins_d;
    logic [WORD_W-1:0] npc_q, npc_d;

    always_comb begin
        // NOTE: every _d takes its held value first, so no path through the block leaves it unassigned and no latch is inferred.
        valid_d = valid_q;
        ins_d   = ins_q;
        npc_d   = npc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            ins_d   = d_ins;
            npc_d   = d_npc;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values whatever the statement order.
        if (RST) begin
            valid_q <= 1'b0;
            ins_q   <= '0;
            npc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ins_q   <= ins_d;
            npc_q   <= npc_d;
        end
    end

    assign valid = valid_q;
    assign q_ins = ins_q;
    assign q_npc = npc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the I-memory read port and hands registered
// instructions to decode. Define FETCH_SKID_EN to add a one-entry skid buffer behind the output.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned       WORD_W = 32,
    parameter logic [WORD_W-1:0] PC0    = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              stall,
    input  logic              redirect,
    input  logic [WORD_W-1:0] redirectPC,
    input  logic              halt,
    output logic [WORD_W-1:0] ins,
    output logic [WORD_W-1:0] npc,
    output logic              insValid,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ins_q, ins_d;
    logic [WORD_W-1:0] npc_q, npc_d;
    logic [WORD_W-1:0] pend_pc_q, pend_pc_d;
    logic              ins_valid_q, ins_valid_d;
    logic              halt_pend_q, halt_pend_d;

    logic [WORD_W-1:0] pc_inc;
    logic [WORD_W-1:0] redirect_pc;
    logic              out_full;
    logic              fetch_fire;
    logic              req_open;

    assign pc_inc      = pc_q + WORD_W'(PC_INC);
    assign redirect_pc = {redirectPC[WORD_W-1:2], 2'b00};

`ifdef FETCH_SKID_EN
    logic              skid_valid;
    logic              skid_load;
    logic              skid_unload;
    logic              skid_flush;
    logic [WORD_W-1:0] skid_ins;
    logic [WORD_W-1:0] skid_npc;

    fetch_skid_buf #(.WORD_W(WORD_W)) u_skid (
        .CLK    (CLK),
        .RST    (RST),
        .load   (skid_load),
        .unload (skid_unload),
        .flush  (skid_flush),
        .d_ins  (iload),
        .d_npc  (pc_inc),
        .valid  (skid_valid),
        .q_ins  (skid_ins),
        .q_npc  (skid_npc)
    );

    assign out_full = ins_valid_q && skid_valid;
`else
    assign out_full = ins_valid_q && stall;
`endif

    // A request already on the bus can never be withdrawn, so a redirect/halt against it must wait in DROP.
    assign iREN       = !RST && (((state_q == FETCH) && !out_full) || (state_q == DROP));
    assign fetch_fire = (state_q == FETCH) && iREN && ihit;
    assign req_open   = iREN && !ihit;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        npc_d       = npc_q;
        ins_valid_d = ins_valid_q;
        pend_pc_d   = pend_pc_q;
        halt_pend_d = halt_pend_q;
`ifdef FETCH_SKID_EN
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = halt || redirect;
`endif
        if (halt || redirect) begin
            ins_valid_d = 1'b0;
        end

        unique case (state_q)
            FETCH: begin
                if (halt) begin
                    if (req_open) begin
                        state_d     = DROP;
                        halt_pend_d = 1'b1;
                    end else begin
                        state_d = HALTED;
                    end
                end else if (redirect) begin
                    if (req_open) begin
                        state_d   = DROP;
                        pend_pc_d = redirect_pc;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (fetch_fire) begin
                    pc_d = pc_inc;
`ifdef FETCH_SKID_EN
                    if (ins_valid_q && stall) begin
                        skid_load = 1'b1;
                    end else begin
                        ins_d       = iload;
                        npc_d       = pc_inc;
                        ins_valid_d = 1'b1;
                    end
`else
                    ins_d       = iload;
                    npc_d       = pc_inc;
                    ins_valid_d = 1'b1;
`endif
                end else if (!stall) begin
`ifdef FETCH_SKID_EN
                    if (skid_valid) begin
                        ins_d       = skid_ins;
                        npc_d       = skid_npc;
                        skid_unload = 1'b1;
                    end else begin
                        ins_valid_d = 1'b0;
                    end
`else
                    ins_valid_d = 1'b0;
`endif
                end
            end
            DROP: begin
                if (redirect) begin
                    pend_pc_d = redirect_pc;
                end
                if (halt) begin
                    halt_pend_d = 1'b1;
                end
                if (ihit) begin
                    if (halt_pend_q || halt) begin
                        state_d = HALTED;
                    end else begin
                        pc_d    = redirect ? redirect_pc : pend_pc_q;
                        state_d = FETCH;
                    end
                end
            end
            HALTED: begin
                ins_valid_d = 1'b0;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= FETCH;
            pc_q        <= PC0;
            ins_q       <= '0;
            npc_q       <= '0;
            ins_valid_q <= 1'b0;
            pend_pc_q   <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            npc_q       <= npc_d;
            ins_valid_q <= ins_valid_d;
            pend_pc_q   <= pend_pc_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign iaddr    = pc_q;
    assign ins      = ins_q;
    assign npc      = npc_q;
    assign insValid = ins_valid_q;
    assign halted   = (state_q == HALTED);

endmodule
